if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register, issues word fetches to instruction memory over a request/grant/response handshake, and absorbs memory latency.
- Handles redirects from EX (branch/jump) and stalls from the hazard unit.
- Drives instrF/pcF/pcplus4F/validF straight into the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0013, instruction driven on instrF when validF=0 (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
stallF  input  1  hazard unit: hold current outputs, do not consume
redirectE  input  1  branch taken / jump resolved in EX
pctargetE  input  32  redirect target; bits [1:0] ignored (treated as 0)
imem_req  output  1  fetch request
imem_addr  output  32  fetch word address
imem_gnt  input  1  memory accepts request this cycle (imem_req && imem_gnt = handshake)
imem_rvalid  input  1  response valid, earliest 1 cycle after grant
imem_rdata  input  32  response instruction
instrF  output  32  fetched instruction (NOP_INSTR when validF=0)
pcF  output  32  address of instrF
pcplus4F  output  32  pcF+4
validF  output  1  instrF/pcF/pcplus4F hold a real instruction

Behaviour:
- Reset (async):
  - pc_q=RESET_PC, state=IDLE, validF=0, instrF=NOP_INSTR, pcF=0, pcplus4F=0, kill=0, skid empty.
  - imem_req=0 while reset is high.
- At most one outstanding memory request. Consumption: output is taken when validF && !stallF.
- States:
  - IDLE: imem_req=1 and imem_addr=pc_q when no redirectE and the output can accept (!validF || !stallF). On grant: fa_q<=pc_q, pc_q<=pc_q+4, go to WAIT. No grant: stay.
  - WAIT: imem_req=0. On imem_rvalid:
    - kill=1: discard the response, clear kill, go to IDLE.
    - output free (!validF || !stallF): load instrF=imem_rdata, pcF=fa_q, pcplus4F=fa_q+4, validF=1 next cycle, go to IDLE.
    - validF && stallF: write {rdata,fa_q} into the 1-entry skid, go to HOLD.
  - HOLD: imem_req=0. On the first cycle with !stallF, move the skid into the output registers (validF=1), empty the skid, go to IDLE.
- Output registers:
  - Consumed with no new instruction loaded the same edge: validF<=0, instrF<=NOP_INSTR. pcF and pcplus4F keep their last values.
  - stallF=1: all outputs hold exactly.
- Redirect (priority over stall and over every state):
  - Same cycle: imem_req forced to 0.
  - Next edge: pc_q<={pctargetE[31:2],2'b00}, validF<=0, instrF<=NOP_INSTR, skid emptied.
  - From WAIT: kill<=1, stay in WAIT. From IDLE or HOLD: go to IDLE.
  - Redirect in the same cycle as imem_rvalid from WAIT: the response is discarded and the state goes to IDLE.
- Arithmetic: all PC adds are 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- Throughput:
  - 1-cycle memory (rvalid the cycle after grant) alternates IDLE and WAIT, giving one instruction per 2 cycles.
  - This is accepted; no prefetch.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt[31:0], reset to 0.
  - Increments by 1 on every edge where an instruction is consumed (validF && !stallF && !redirectE).
  - Wraps modulo 2^32.
- Undefined: no port and no counter logic.

Test Plan:
- Reset, then 1-cycle-latency memory returning rdata=addr^32'hA5A5_0000, stallF=0:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - pcF=0x0 instrF=0xA5A5_0000 validF=1, then pcF=0x4 pcplus4F=0x8.
- Redirect to 0x0000_0103 while in WAIT:
  - Pending response is dropped and never appears with validF=1.
  - Next imem_addr=0x0000_0100. Next valid pcF=0x100.
- Hold stallF=1 for 5 cycles with validF=1 and a response landing in the skid:
  - Outputs are frozen and imem_req=0.
  - After release, the held instruction is presented once, then the skid instruction, then fetching resumes. No loss or duplication.
- Redirect to 0xFFFF_FFFC:
  - pcF=0xFFFF_FFFC, pcplus4F=0x0.
  - Next imem_addr=0x0.
- Assert reset asynchronously mid-WAIT:
  - Outputs go to reset values without a clock edge.
  - A late imem_rvalid after reset deasserts is ignored.
  - First imem_addr=RESET_PC.
- IF_PERF_CNT_EN defined, 10 instructions consumed with 2 stall cycles and 1 redirect interleaved:
  - fetch_cnt=10.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
// A transfer is accepted on a cycle with imem_req && imem_gnt; the response
// comes back later as a single imem_rvalid pulse carrying imem_rdata.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time over the
// imem handshake, and presents instrF/pcF/pcplus4F/validF to the IF/ID register.
// A one-entry skid buffer catches a response that arrives while the output is
// stalled. Optional macro IF_PERF_CNT_EN adds a consumed-instruction counter.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirectE,
  input  logic [31:0] pctargetE,
  if_stage_if.master  imem,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F,
  output logic        validF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;           // address of the outstanding fetch
  logic        kill_q, kill_d;       // drop the outstanding response
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcp4_q, pcp4_d;

  logic        can_accept;
  logic        consume;
  logic        fetch_req;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  // Low address bits of the redirect target are forced to zero.
  logic unused_target_bits;
  assign unused_target_bits = ^pctargetE[1:0];

  assign can_accept = !valid_q || !stallF;
  assign consume    = valid_q && !stallF;
  assign fetch_req  = (state_q == StIdle) && !redirectE && can_accept && !reset;

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc_q;

  assign instrF   = instr_q;
  assign pcF      = pcf_q;
  assign pcplus4F = pcp4_q;
  assign validF   = valid_q;

  // Next-state: fetch FSM, skid buffer and output registers, redirect last.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fa_d         = fa_q;
    kill_d       = kill_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pcf_d        = pcf_q;
    pcp4_d       = pcp4_q;
    load         = 1'b0;
    load_instr   = imem.imem_rdata;
    load_pc      = fa_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_req && imem.imem_gnt) begin
          fa_d    = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem.imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StIdle;
          end else if (can_accept) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            skid_vld_d   = 1'b1;
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = fa_q;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (!stallF) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          skid_vld_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A newly loaded instruction wins over draining the consumed one.
    if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pcf_d   = load_pc;
      pcp4_d  = load_pc + 32'd4;
    end else if (consume) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    // Redirect overrides stall and every state transition above.
    if (redirectE) begin
      pc_d       = {pctargetE[31:2], 2'b00};
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      pcf_d      = pcf_q;
      pcp4_d     = pcp4_q;
      skid_vld_d = 1'b0;
      if (state_q == StWait && !imem.imem_rvalid) begin
        kill_d  = 1'b1;
        state_d = StWait;
      end else begin
        kill_d  = 1'b0;
        state_d = StIdle;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      fa_q         <= '0;
      kill_q       <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pcf_q        <= '0;
      pcp4_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fa_q         <= fa_d;
      kill_q       <= kill_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pcf_q        <= pcf_d;
      pcp4_q       <= pcp4_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  assign fetch_cnt = fetch_cnt_q;

  // Count instructions handed to decode; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
    end else if (consume && !redirectE) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end
`endif

endmodule
